// File: rtl/eth_fcs_tx_ctrl.sv
// eth_fcs_tx_ctrl: passes an upstream byte stream to the MAC, zero-pads short frames
// and appends the FCS produced by an external byte-wide CRC-32 engine.
module eth_fcs_tx_ctrl #(
    parameter int MIN_LEN = 60,
    parameter bit PAD_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        out_ready,
    output logic        crc_init,
    output logic        crc_calc,
    output logic [7:0]  crc_d,
    output logic        crc_d_valid,
    input  logic [7:0]  crc_byte,
    output logic        frame_done,
    output logic [31:0] frame_count
);
    typedef enum logic [2:0] {IDLE, DATA, PAD, FCS0, FCS1, FCS2, FCS3} state_t;
    localparam logic [6:0] MIN_L = 7'(MIN_LEN);
    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d, cnt_inc;
    logic        fire, frame_done_q;
    logic [31:0] frame_count_q;
    assign cnt_inc     = (cnt_q < MIN_L) ? cnt_q + 7'd1 : cnt_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data    = in_data;
        out_valid   = 1'b0;
        out_sop     = 1'b0;
        out_eop     = 1'b0;
        in_ready    = 1'b0;
        crc_calc    = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready  = in_sop ? out_ready : 1'b1;
                out_valid = in_valid & in_sop;
                out_sop   = in_valid & in_sop;
            end
            DATA: begin
                in_ready  = out_ready;
                out_valid = in_valid;
            end
            PAD: begin
                out_data  = 8'h00;
                out_valid = 1'b1;
            end
            default: begin
                out_data  = crc_byte;
                out_valid = 1'b1;
                crc_calc  = 1'b0;
                out_eop   = (state_q == FCS3);
            end
        endcase
        fire = out_valid & out_ready;
        if (fire) begin
            case (state_q)
                IDLE, DATA: begin
                    cnt_d   = cnt_inc;
                    state_d = in_eop ? ((PAD_EN && cnt_inc < MIN_L) ? PAD : FCS0) : DATA;
                end
                PAD: begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == MIN_L) ? FCS0 : PAD;
                end
                FCS0: state_d = FCS1;
                FCS1: state_d = FCS2;
                FCS2: state_d = FCS3;
                default: begin
                    cnt_d   = 7'd0;
                    state_d = IDLE;
                end
            endcase
        end
        // The last FCS byte needs no shift: the engine is re-initialised instead.
        crc_init    = fire & (state_q == FCS3);
        crc_d       = out_data;
        crc_d_valid = fire & ~crc_init;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 7'd0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_done_q  <= crc_init;
            if (crc_init) frame_count_q <= frame_count_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// tb_eth_fcs_tx_ctrl: scoreboard bench for eth_fcs_tx_ctrl with a behavioural CRC-32 engine
// per instance; PAD_EN=0 and PAD_EN=1 instances share the stimulus, sel picks the one checked.
module tb_eth_fcs_tx_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [7:0]  in_data;
    logic        in_valid, in_sop, in_eop, out_ready;
    logic [7:0]  od0, od1, cd0, cd1, cb0, cb1;
    logic        ir0, ir1, ov0, ov1, os0, os1, oe0, oe1;
    logic        ci0, ci1, cc0, cc1, cv0, cv1, fd0, fd1;
    logic [31:0] fc0, fc1, c0, c1;
    bit          sel, rnd_rdy, hold_en, hv;
    logic [7:0]  hd;
    logic [9:0]  sb[$];
    int          n_cmp, n_bad, n_init, n_done, init_at_sop;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign cb0 = ~c0[7:0];
    assign cb1 = ~c1[7:0];
    always_ff @(posedge clk or posedge rst)
        if (rst) c0 <= '1;
        else if (ci0) c0 <= '1;
        else if (cv0) c0 <= cc0 ? crc_upd(c0, cd0) : {8'hFF, c0[31:8]};
    always_ff @(posedge clk or posedge rst)
        if (rst) c1 <= '1;
        else if (ci1) c1 <= '1;
        else if (cv1) c1 <= cc1 ? crc_upd(c1, cd1) : {8'hFF, c1[31:8]};

    eth_fcs_tx_ctrl #(.MIN_LEN(60), .PAD_EN(1'b0)) u0 (
        .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_sop(os0),
        .out_eop(oe0), .out_ready(out_ready), .crc_init(ci0), .crc_calc(cc0), .crc_d(cd0),
        .crc_d_valid(cv0), .crc_byte(cb0), .frame_done(fd0), .frame_count(fc0));
    eth_fcs_tx_ctrl #(.MIN_LEN(60), .PAD_EN(1'b1)) u1 (
        .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_sop(os1),
        .out_eop(oe1), .out_ready(out_ready), .crc_init(ci1), .crc_calc(cc1), .crc_d(cd1),
        .crc_d_valid(cv1), .crc_byte(cb1), .frame_done(fd1), .frame_count(fc1));

    wire [7:0]  m_od = sel ? od1 : od0;
    wire        m_ov = sel ? ov1 : ov0;
    wire        m_os = sel ? os1 : os0;
    wire        m_oe = sel ? oe1 : oe0;
    wire        m_ir = sel ? ir1 : ir0;
    wire        m_ci = sel ? ci1 : ci0;
    wire        m_cv = sel ? cv1 : cv0;
    wire        m_fd = sel ? fd1 : fd0;
    wire [31:0] m_fc = sel ? fc1 : fc0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input logic [7:0] e[$], input bit eop_last);
        foreach (e[i]) sb.push_back({e[i], i == 0, eop_last && i == e.size() - 1});
    endtask

    task automatic exp_frame(input logic [7:0] d[$], input bit pad);
        logic [7:0]  e[$];
        logic [31:0] c;
        e = d;
        if (pad) while (e.size() < 60) e.push_back(8'h00);
        c = '1;
        foreach (e[i]) c = crc_upd(c, e[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
        exp_push(e, 1'b1);
    endtask

    task automatic push_byte(input logic [7:0] d, input bit s, input bit e, input bit gaps);
        bit acc;
        int n;
        while (gaps && $urandom_range(1, 0) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data = d; in_valid = 1'b1; in_sop = s; in_eop = e;
        acc = 1'b0; n = 0;
        while (!acc && n < 2000) begin
            @(negedge clk);
            acc = m_ir;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send(input logic [7:0] d[$], input bit gaps);
        foreach (d[i]) push_byte(d[i], i == 0, i == d.size() - 1, gaps);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        rnd_rdy = 1'b0;
        hold_en = 1'b0;
        chk("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        rnd_rdy = 1'b0; hold_en = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_init = 0; n_done = 0; init_at_sop = -1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d[$], digits[$], e[$];
        in_data = 8'h00; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 9; i++) digits.push_back(8'h31 + 8'(i));
        fork
            forever begin
                @(posedge clk); #1;
                if (rnd_rdy) out_ready = 1'($urandom_range(1, 0));
            end
            forever begin
                logic [9:0] x;
                @(negedge clk);
                if (rst) hv = 1'b0;
                else begin
                    if (m_ci) begin n_init++; chk("init_with_dvalid", m_cv, 0); end
                    if (m_fd) n_done++;
                    if (hold_en && hv) begin
                        chk("hold_valid", m_ov, 1);
                        chk("hold_data", m_od, hd);
                    end
                    hv = m_ov && !out_ready;
                    hd = m_od;
                    if (m_ov && out_ready) begin
                        if (m_os) init_at_sop = n_init;
                        if (sb.size() == 0) chk("extra_output", 1, 0);
                        else begin
                            x = sb.pop_front();
                            chk("out_data", m_od, x[9:2]);
                            chk("out_sop", m_os, x[1]);
                            chk("out_eop", m_oe, x[0]);
                        end
                    end
                end
            end
        join_none

        // reset state and IDLE handshake just after release
        sel = 1'b1;
        do_reset();
        chk("rst_frame_count", m_fc, 0);
        chk("rst_frame_done", m_fd, 0);
        chk("rst_crc_init", m_ci, 0);
        in_valid = 1'b1; in_sop = 1'b0;
        @(negedge clk);
        chk("idle_nonsop_valid", m_ov, 0);
        chk("idle_nonsop_ready", m_ir, 1);
        @(posedge clk); #1;
        in_sop = 1'b1;
        @(negedge clk);
        chk("idle_sop_valid", m_ov, 1);
        chk("idle_sop_ready", m_ir, 0);
        chk("idle_sop_flag", m_os, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0;

        // "123456789" without padding: known FCS
        sel = 1'b0;
        do_reset();
        out_ready = 1'b1;
        e = digits;
        e.push_back(8'h26); e.push_back(8'h39); e.push_back(8'hF4); e.push_back(8'hCB);
        exp_push(e, 1'b1);
        send(digits, 1'b0);
        drain();
        chk("t25_frame_count", m_fc, 1);
        chk("t25_frame_done", n_done, 1);

        // single zero byte padded to 60
        sel = 1'b1;
        do_reset();
        out_ready = 1'b1;
        d = {8'h00};
        exp_frame(d, 1'b1);
        send(d, 1'b0);
        drain();
        chk("t26_frame_count", m_fc, 1);

        // 64 random bytes, random backpressure and source gaps
        do_reset();
        d.delete();
        for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
        exp_frame(d, 1'b1);
        rnd_rdy = 1'b1; hold_en = 1'b1;
        send(d, 1'b1);
        drain();
        out_ready = 1'b1;
        chk("t27_frame_count", m_fc, 1);

        // stray non-SOP bytes in IDLE are dropped
        do_reset();
        out_ready = 1'b1;
        push_byte(8'hAA, 1'b0, 1'b0, 1'b0);
        push_byte(8'hBB, 1'b0, 1'b1, 1'b0);
        push_byte(8'hCC, 1'b0, 1'b0, 1'b0);
        d.delete();
        for (int i = 0; i < 61; i++) d.push_back(8'(i * 7 + 1));
        exp_frame(d, 1'b1);
        send(d, 1'b0);
        drain();
        chk("t28_frames", n_done, 1);
        chk("t28_frame_count", m_fc, 1);

        // reset mid-frame, then a clean frame
        sel = 1'b0;
        do_reset();
        out_ready = 1'b1;
        d.delete();
        for (int i = 0; i < 10; i++) d.push_back(8'hA0 + 8'(i));
        exp_push(d, 1'b0);
        foreach (d[i]) push_byte(d[i], i == 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t29_partial_out", sb.size(), 0);
        chk("t29_abort_done", n_done, 0);
        do_reset();
        chk("t29_count_cleared", m_fc, 0);
        out_ready = 1'b1;
        e = digits;
        e.push_back(8'h26); e.push_back(8'h39); e.push_back(8'hF4); e.push_back(8'hCB);
        exp_push(e, 1'b1);
        send(digits, 1'b0);
        drain();
        chk("t29_frame_count", m_fc, 1);
        chk("t29_frame_done", n_done, 1);

        // back-to-back frames
        sel = 1'b1;
        do_reset();
        out_ready = 1'b1;
        d.delete();
        for (int i = 0; i < 60; i++) d.push_back(8'(i * 3));
        e.delete();
        for (int i = 0; i < 62; i++) e.push_back(~8'(i));
        exp_frame(d, 1'b1);
        exp_frame(e, 1'b1);
        send(d, 1'b0);
        send(e, 1'b0);
        drain();
        chk("t30_init_between", init_at_sop, 1);
        chk("t30_init_total", n_init, 2);
        chk("t30_frames", n_done, 2);
        chk("t30_frame_count", m_fc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
